// File: rtl/calc_port_responder_if.sv
// Request/response bundle for the calc port; the requester drives req_*, the
// responder drives out_*. Data vectors are big-endian: bit 0 is the MSB.
interface calc_port_responder_if #(
  parameter int DATA_W = 32
);
  // No valid/ready pair. A nonzero req_cmd_in is a request and is taken only
  // while the responder is idle; req_data_in carries operand 1 in that cycle
  // and operand 2 in the next. A nonzero out_resp marks a single-cycle response.
  logic [3:0]        req_cmd_in;
  logic [0:DATA_W-1] req_data_in;
  logic [1:0]        out_resp;
  logic [0:DATA_W-1] out_data;

  modport master (output req_cmd_in, req_data_in, input out_resp, out_data);
  modport slave  (input req_cmd_in, req_data_in, output out_resp, out_data);
endinterface

// File: rtl/calc_port_responder.sv
// Single-channel calc port responder: two-cycle request, add/sub/shl/shr, one-cycle response.
// Optional dropped-command counter enabled by defining CALC_DROP_CNT_EN.
module calc_port_responder #(
  parameter int DATA_W       = 32,
  parameter int RESP_LATENCY = 1
) (
  input  logic                  c_clk,
  input  logic                  reset,
  calc_port_responder_if.slave  port,
  output logic [1:0]            state_dbg
`ifdef CALC_DROP_CNT_EN
  , output logic [7:0]          out_drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, OP2 = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam int         WAIT_LAST_I = (RESP_LATENCY > 1) ? RESP_LATENCY - 2 : 0;
  localparam logic [1:0] WAIT_LAST   = 2'(WAIT_LAST_I);

  state_t            state, state_nxt;
  logic [1:0]        wait_cnt, wait_cnt_nxt;
  logic [3:0]        cmd_q;
  logic [0:DATA_W-1] op1_q, op2_q;
  logic [1:0]        resp_q;
  logic [0:DATA_W-1] data_q;

  logic [1:0]        res_resp;
  logic [0:DATA_W-1] res_data;
  logic [DATA_W:0]   sum;
  logic [4:0]        sh;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: if (port.req_cmd_in != 4'd0) state_nxt = OP2;
      OP2: begin
        wait_cnt_nxt = 2'd0;
        state_nxt    = (RESP_LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nxt = RESP;
        else                       wait_cnt_nxt = wait_cnt + 2'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result depends only on captured registers, so late input changes cannot leak in.
  always_comb begin
    res_resp = 2'd2;
    res_data = '0;
    sum      = {1'b0, op1_q} + {1'b0, op2_q};
    sh       = op2_q[DATA_W-5 +: 5];
    case (cmd_q)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          res_resp = 2'd1;
          res_data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2_q <= op1_q) begin
          res_resp = 2'd1;
          res_data = op1_q - op2_q;
        end
      end
      CMD_SHL: begin
        res_resp = 2'd1;
        res_data = op1_q << sh;
      end
      CMD_SHR: begin
        res_resp = 2'd1;
        res_data = op1_q >> sh;
      end
      default: begin
        res_resp = 2'd2;
        res_data = '0;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      cmd_q    <= 4'd0;
      op1_q    <= '0;
      op2_q    <= '0;
      resp_q   <= 2'd0;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == IDLE && port.req_cmd_in != 4'd0) begin
        cmd_q <= port.req_cmd_in;
        op1_q <= port.req_data_in;
      end
      if (state == OP2) op2_q <= port.req_data_in;
      // The response registers load on the edge leaving RESP and self-clear one edge later.
      if (state == RESP) begin
        resp_q <= res_resp;
        data_q <= res_data;
      end else begin
        resp_q <= 2'd0;
        data_q <= '0;
      end
    end
  end

  assign port.out_resp = resp_q;
  assign port.out_data = data_q;
  assign state_dbg     = state;

`ifdef CALC_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      drop_q <= 8'd0;
    end else if (state != IDLE && port.req_cmd_in != 4'd0 && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign out_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder: two instances (RESP_LATENCY 1 and 4)
// share clock, reset and request stimulus.
module tb_calc_port_responder;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cmd   = 4'd0;
  logic [31:0] data  = 32'd0;
  logic [1:0]  state_dbg1, state_dbg4;
`ifdef CALC_DROP_CNT_EN
  logic [7:0]  drop1, drop4;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  // Observations captured by run_op
  logic [1:0]  r1_resp, r1_after_resp, r4_pre_resp, r4_resp, r4_after_resp;
  logic [31:0] r1_data, r1_after_data, r4_data;

  always #5 c_clk = ~c_clk;

  calc_port_responder_if #(.DATA_W(32)) if1 ();
  calc_port_responder_if #(.DATA_W(32)) if4 ();

  assign if1.req_cmd_in  = cmd;
  assign if1.req_data_in = data;
  assign if4.req_cmd_in  = cmd;
  assign if4.req_data_in = data;

  calc_port_responder #(.DATA_W(32), .RESP_LATENCY(1)) dut1 (
    .c_clk(c_clk), .reset(reset), .port(if1.slave), .state_dbg(state_dbg1)
`ifdef CALC_DROP_CNT_EN
    , .out_drop_cnt(drop1)
`endif
  );

  calc_port_responder #(.DATA_W(32), .RESP_LATENCY(4)) dut4 (
    .c_clk(c_clk), .reset(reset), .port(if4.slave), .state_dbg(state_dbg4)
`ifdef CALC_DROP_CNT_EN
    , .out_drop_cnt(drop4)
`endif
  );

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic idle(input int n);
    cmd = 4'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Issue one request; sample dut1 at N+2/N+3 and dut4 at N+4/N+5/N+6.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    cmd = c; data = a; tick();             // edge N
    cmd = 4'd0; data = b; tick();          // edge N+1
    data = $urandom; tick();               // edge N+2
    r1_resp = if1.out_resp; r1_data = if1.out_data;
    data = $urandom; tick();               // edge N+3
    r1_after_resp = if1.out_resp; r1_after_data = if1.out_data;
    tick();                                // edge N+4
    r4_pre_resp = if4.out_resp;
    tick();                                // edge N+5
    r4_resp = if4.out_resp; r4_data = if4.out_data;
    tick();                                // edge N+6
    r4_after_resp = if4.out_resp;
    data = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd = 4'd0; data = 32'd0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (if1.out_resp !== 2'd0) begin failures++; $display("FAIL reset_resp1: got %0d expected 0", if1.out_resp); end
    checks++; if (if1.out_data !== 32'd0) begin failures++; $display("FAIL reset_data1: got %h expected 0", if1.out_data); end
    checks++; if (if4.out_resp !== 2'd0) begin failures++; $display("FAIL reset_resp4: got %0d expected 0", if4.out_resp); end
    checks++; if (state_dbg1 !== 2'd0) begin failures++; $display("FAIL reset_state1: got %0d expected 0", state_dbg1); end
`ifdef CALC_DROP_CNT_EN
    checks++; if (drop1 !== 8'd0) begin failures++; $display("FAIL reset_drop1: got %0d expected 0", drop1); end
`endif
  endtask

  task automatic test_add();
    run_op(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    checks++; if (r1_resp !== 2'd1) begin failures++; $display("FAIL add_resp1: got %0d expected 1", r1_resp); end
    checks++; if (r1_data !== 32'h3FFF_FFFE) begin failures++; $display("FAIL add_data1: got %h expected 3ffffffe", r1_data); end
    checks++; if (r1_after_resp !== 2'd0) begin failures++; $display("FAIL add_clear_resp1: got %0d expected 0", r1_after_resp); end
    checks++; if (r1_after_data !== 32'd0) begin failures++; $display("FAIL add_clear_data1: got %h expected 0", r1_after_data); end
    checks++; if (r4_pre_resp !== 2'd0) begin failures++; $display("FAIL add_early4: got %0d expected 0", r4_pre_resp); end
    checks++; if (r4_resp !== 2'd1) begin failures++; $display("FAIL add_resp4: got %0d expected 1", r4_resp); end
    checks++; if (r4_data !== 32'h3FFF_FFFE) begin failures++; $display("FAIL add_data4: got %h expected 3ffffffe", r4_data); end
    checks++; if (r4_after_resp !== 2'd0) begin failures++; $display("FAIL add_clear_resp4: got %0d expected 0", r4_after_resp); end
    run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++; if (r1_resp !== 2'd2) begin failures++; $display("FAIL add_ovf_resp1: got %0d expected 2", r1_resp); end
    checks++; if (r1_data !== 32'd0) begin failures++; $display("FAIL add_ovf_data1: got %h expected 0", r1_data); end
    checks++; if (r4_resp !== 2'd2) begin failures++; $display("FAIL add_ovf_resp4: got %0d expected 2", r4_resp); end
  endtask

  task automatic test_sub();
    run_op(4'd2, 32'd1, 32'd15);
    checks++; if (r1_resp !== 2'd2) begin failures++; $display("FAIL sub_under_resp: got %0d expected 2", r1_resp); end
    checks++; if (r1_data !== 32'd0) begin failures++; $display("FAIL sub_under_data: got %h expected 0", r1_data); end
    run_op(4'd2, 32'd15, 32'd15);
    checks++; if (r1_resp !== 2'd1) begin failures++; $display("FAIL sub_eq_resp: got %0d expected 1", r1_resp); end
    checks++; if (r1_data !== 32'd0) begin failures++; $display("FAIL sub_eq_data: got %h expected 0", r1_data); end
    run_op(4'd2, 32'd100, 32'd58);
    checks++; if (r1_resp !== 2'd1) begin failures++; $display("FAIL sub_resp: got %0d expected 1", r1_resp); end
    checks++; if (r1_data !== 32'd42) begin failures++; $display("FAIL sub_data: got %h expected 2a", r1_data); end
    checks++; if (r4_data !== 32'd42) begin failures++; $display("FAIL sub_data4: got %h expected 2a", r4_data); end
  endtask

  task automatic test_shift();
    run_op(4'd5, 32'h0000_0001, 32'd31);
    checks++; if (r1_resp !== 2'd1) begin failures++; $display("FAIL shl31_resp: got %0d expected 1", r1_resp); end
    checks++; if (r1_data !== 32'h8000_0000) begin failures++; $display("FAIL shl31_data: got %h expected 80000000", r1_data); end
    run_op(4'd6, 32'h8000_0000, 32'd31);
    checks++; if (r1_resp !== 2'd1) begin failures++; $display("FAIL shr31_resp: got %0d expected 1", r1_resp); end
    checks++; if (r1_data !== 32'h0000_0001) begin failures++; $display("FAIL shr31_data: got %h expected 1", r1_data); end
    run_op(4'd5, 32'h0000_0001, 32'h0000_0021);
    checks++; if (r1_data !== 32'h0000_0002) begin failures++; $display("FAIL shl_mask_data: got %h expected 2", r1_data); end
    run_op(4'd6, 32'hA5A5_A5A5, 32'h0000_0020);
    checks++; if (r1_data !== 32'hA5A5_A5A5) begin failures++; $display("FAIL shr0_data: got %h expected a5a5a5a5", r1_data); end
    run_op(4'd5, 32'hF000_000F, 32'd4);
    checks++; if (r1_resp !== 2'd1) begin failures++; $display("FAIL shl_lost_resp: got %0d expected 1", r1_resp); end
    checks++; if (r1_data !== 32'h0000_00F0) begin failures++; $display("FAIL shl_lost_data: got %h expected f0", r1_data); end
  endtask

  task automatic test_invalid();
    run_op(4'd3, 32'd1, 32'd1);
    checks++; if (r1_resp !== 2'd2) begin failures++; $display("FAIL inv3_resp1: got %0d expected 2", r1_resp); end
    checks++; if (r1_data !== 32'd0) begin failures++; $display("FAIL inv3_data1: got %h expected 0", r1_data); end
    checks++; if (r4_resp !== 2'd2) begin failures++; $display("FAIL inv3_resp4: got %0d expected 2", r4_resp); end
    run_op(4'd4, 32'd7, 32'd9);
    checks++; if (r1_resp !== 2'd2) begin failures++; $display("FAIL inv4_resp: got %0d expected 2", r1_resp); end
    run_op(4'd15, 32'd7, 32'd9);
    checks++; if (r1_resp !== 2'd2) begin failures++; $display("FAIL inv15_resp: got %0d expected 2", r1_resp); end
  endtask

  task automatic test_reset_midop();
    int seen;
    // Reset while both instances are in OP2.
    cmd = 4'd1; data = 32'd7; tick();
    cmd = 4'd0; data = 32'd9; reset = 1'b1; tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      if (if1.out_resp != 2'd0 || if4.out_resp != 2'd0 || if1.out_data != 32'd0) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rst_op2_pulse: got %0d pulses expected 0", seen); end
    // Reset with dut1 in RESP and dut4 in WAIT.
    cmd = 4'd1; data = 32'd7; tick();
    cmd = 4'd0; data = 32'd9; tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      if (if1.out_resp != 2'd0 || if4.out_resp != 2'd0 || if4.out_data != 32'd0) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rst_wait_pulse: got %0d pulses expected 0", seen); end
    checks++; if (state_dbg4 !== 2'd0) begin failures++; $display("FAIL rst_wait_state4: got %0d expected 0", state_dbg4); end
    run_op(4'd1, 32'd2, 32'd3);
    checks++; if (r1_resp !== 2'd1 || r1_data !== 32'd5) begin failures++; $display("FAIL rst_fresh1: got %0d/%h expected 1/5", r1_resp, r1_data); end
    checks++; if (r4_resp !== 2'd1 || r4_data !== 32'd5) begin failures++; $display("FAIL rst_fresh4: got %0d/%h expected 1/5", r4_resp, r4_data); end
  endtask

  // Commands in OP2 and RESP are dropped; the next IDLE cycle accepts back-to-back.
  task automatic test_back_to_back();
    logic [31:0] exp_v;
    reset = 1'b1; tick(); reset = 1'b0;
    exp_q.push_back(32'd30);
    exp_q.push_back(32'd42);
    cmd = 4'd1; data = 32'd10; tick();     // edge N: accepted
    cmd = 4'd1; data = 32'd20; tick();     // edge N+1: OP2, dropped cmd, op2=20
    cmd = 4'd1; data = 32'd99; tick();     // edge N+2: RESP, dropped
    exp_v = exp_q.pop_front();
    checks++; if (if1.out_resp !== 2'd1 || if1.out_data !== exp_v) begin failures++; $display("FAIL b2b_first: got %0d/%h expected 1/%h", if1.out_resp, if1.out_data, exp_v); end
    cmd = 4'd2; data = 32'd50; tick();     // edge N+3: IDLE, accepted
    checks++; if (if1.out_resp !== 2'd0) begin failures++; $display("FAIL b2b_gap: got %0d expected 0", if1.out_resp); end
    cmd = 4'd0; data = 32'd8; tick();      // edge N+4: OP2
    data = 32'd1; tick();                  // edge N+5: response
    exp_v = exp_q.pop_front();
    checks++; if (if1.out_resp !== 2'd1 || if1.out_data !== exp_v) begin failures++; $display("FAIL b2b_second: got %0d/%h expected 1/%h", if1.out_resp, if1.out_data, exp_v); end
`ifdef CALC_DROP_CNT_EN
    checks++; if (drop1 !== 8'd2) begin failures++; $display("FAIL b2b_drop_cnt: got %0d expected 2", drop1); end
`endif
    idle(8);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_invalid();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
Name: calc_port_responder

Overview:
- Single-channel responder for the calc request/response port protocol: the device end of the interface that request drivers and benches initiate on.
- Accepts a two-cycle request: command plus operand 1, then operand 2.
- Executes add, subtract, shift-left or shift-right and returns a one-cycle response code and result.
- Serves as the reference responder for port-level bring-up and as the per-port execution slice behind future multi-port arbiters.

Parameters:
- DATA_W, 32, operand/result width; bit 0 is the MSB (big-endian bit order, [0:DATA_W-1]).
- RESP_LATENCY, 1, cycles from the operand-2 capture edge to response valid; legal range 1..4.

Ports:
- c_clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_cmd_in  input  4  command: 0 none, 1 add, 2 sub, 5 shl, 6 shr; all other nonzero values are invalid.
- req_data_in  input  DATA_W  operand 1 in the command cycle, operand 2 in the following cycle.
- out_resp  output  2  0 no response, 1 success, 2 overflow/underflow/invalid command, 3 never driven.
- out_data  output  DATA_W  result; valid only while out_resp != 0, otherwise 0.

Behaviour:
- Reset: with reset high at an edge, state goes to IDLE, all pipeline registers clear, out_resp=0 and out_data=0 after that edge. An operation in flight is discarded; no response is ever emitted for it.
- FSM states: IDLE, OP2, WAIT, RESP.
  - IDLE: if req_cmd_in != 0 at the edge, capture the command and operand 1, then go to OP2. Otherwise stay in IDLE.
  - OP2: capture req_data_in as operand 2 unconditionally; req_cmd_in is ignored. Go to WAIT if RESP_LATENCY > 1, else go to RESP.
  - WAIT: count RESP_LATENCY-1 cycles, then go to RESP.
  - RESP: out_resp/out_data are valid for exactly one cycle; then go to IDLE.
- Latency: command captured at edge N, operand 2 at edge N+1, response driven from edge N+1+RESP_LATENCY and cleared at the next edge.
- Busy rule: a nonzero req_cmd_in is sampled only in IDLE. Commands presented in OP2, WAIT or RESP are dropped silently. The earliest back-to-back command is therefore the cycle after the response cycle.
- Add: 33-bit sum.
  - Carry out = 1: out_resp=2, out_data=0.
  - Otherwise: out_resp=1, out_data=sum.
- Sub: operand 1 minus operand 2, unsigned.
  - Operand 2 > operand 1: out_resp=2, out_data=0.
  - Equal operands: out_resp=1, out_data=0.
- Shl/shr: shift amount is the 5 LSBs of operand 2; upper operand-2 bits are ignored.
  - Logical shift, zero fill; shift by 0 returns operand 1.
  - Always out_resp=1; bits shifted out are not an error.
- Invalid command (3, 4, 7..15): the full two-cycle handshake and latency still apply; the response is out_resp=2, out_data=0.
- The response value is computed from captured registers only. Input changes after edge N+1 do not affect it.

Optional Feature:
- Macro: CALC_DROP_CNT_EN.
- Defined:
  - Adds output out_drop_cnt, 8 bits, reset 0.
  - Increments by 1 at each edge where req_cmd_in != 0 and the state is OP2, WAIT or RESP; the OP2 operand cycle counts only if its cmd is nonzero.
  - Saturates at 255.
  - Cleared only by reset.
- Undefined: the port and counter do not exist; drop behaviour is otherwise identical.

Test Plan:
- Add 0x1FFF_FFFF + 0x1FFF_FFFF, RESP_LATENCY=1 -> response at the edge two after the cmd edge: out_resp=1, out_data=0x3FFF_FFFE; next cycle out_resp=0, out_data=0.
- Add 0xFFFF_FFFF + 0x0000_0001 -> out_resp=2, out_data=0. Sub 1 - 15 -> out_resp=2, out_data=0. Sub 15 - 15 -> out_resp=1, out_data=0.
- Shl 0x0000_0001 by 31 -> 0x8000_0000, resp 1. Shr 0x8000_0000 by 31 -> 0x0000_0001. Shl 0x0000_0001 by 0x0000_0021 (amount 1) -> 0x0000_0002.
- cmd 3 with data 1, then cmd 4 -> each gives out_resp=2, out_data=0 with the normal latency.
- Reset asserted in OP2 or WAIT -> no response pulse; outputs 0; a fresh add 2+3 issued afterwards returns 5, resp 1.
- Cmd 1 issued in OP2 and in RESP while busy -> ignored; result unchanged; out_drop_cnt=2 with CALC_DROP_CNT_EN. Run RESP_LATENCY=4 -> response five edges after the cmd edge.
